// File: rtl/clock_pkg.sv
// ============================================================================
// Module      : clock_pkg
// Description : Shared BCD types, limits and increment helpers for the
//               bcd_time_counter timekeeping core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        logic carry;
        bcd_t tens;
        bcd_t ones;
    } bcd_pair_t;

    localparam int SEC_MAX_TENS = 5;
    localparam int MIN_MAX_TENS = 5;
    localparam int HR24_MAX     = 23;
    localparam int HR12_MIN     = 1;
    localparam int HR12_MAX     = 12;

    // Two-digit x9 counter rolling over after {max_tens,9}; carry flags the rollover.
    function automatic bcd_pair_t inc_bcd60(input bcd_t tens, input bcd_t ones, input int max_tens);
        bcd_pair_t r;
        r = '{carry: 1'b0, tens: tens, ones: ones + 4'd1};
        if (ones == 4'd9) begin
            r.ones = 4'd0;
            if (tens == bcd_t'(max_tens)) begin
                r.tens  = 4'd0;
                r.carry = 1'b1;
            end else begin
                r.tens = tens + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic bcd_pair_t inc_hr24(input bcd_t tens, input bcd_t ones);
        bcd_pair_t r;
        r = '{carry: 1'b0, tens: tens, ones: ones + 4'd1};
        if (tens == bcd_t'(HR24_MAX / 10) && ones == bcd_t'(HR24_MAX % 10)) begin
            r = '{carry: 1'b1, tens: 4'd0, ones: 4'd0};
        end else if (ones == 4'd9) begin
            r.tens = tens + 4'd1;
            r.ones = 4'd0;
        end
        return r;
    endfunction

    // Carry here marks the 11 -> 12 step, where the meridiem flips.
    function automatic bcd_pair_t inc_hr12(input bcd_t tens, input bcd_t ones);
        bcd_pair_t r;
        r = '{carry: 1'b0, tens: tens, ones: ones + 4'd1};
        if (tens == bcd_t'(HR12_MAX / 10) && ones == bcd_t'(HR12_MAX % 10)) begin
            r.tens = bcd_t'(HR12_MIN / 10);
            r.ones = bcd_t'(HR12_MIN % 10);
        end else if (tens == bcd_t'((HR12_MAX - 1) / 10) && ones == bcd_t'((HR12_MAX - 1) % 10)) begin
            r.carry = 1'b1;
        end else if (ones == 4'd9) begin
            r.tens = tens + 4'd1;
            r.ones = 4'd0;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module      : tick_gen
// Description : Prescaler producing a registered one-cycle tick every
//               CLK_FREQ_HZ enabled cycles, with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic sec_tick
);

    localparam int CW = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [CW-1:0] c_term_count = CW'(CLK_FREQ_HZ - 1);

    logic [CW-1:0] r_count;
    logic          r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (run) begin
            if (r_count == c_term_count) begin
                r_count <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_count <= r_count + CW'(1);
                r_tick  <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign sec_tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/bcd_time_counter.sv
// ============================================================================
// Module      : bcd_time_counter
// Description : HH:MM:SS BCD timekeeper with minute/hour set pulses.
//               Define HR12_MODE_EN for 12-hour display with pm output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       set_min,
    input  logic       set_hr,
    output logic [3:0] sec_1s,
    output logic [3:0] sec_10s,
    output logic [3:0] min_1s,
    output logic [3:0] min_10s,
    output logic [3:0] hr_1s,
    output logic [3:0] hr_10s,
    output logic       sec_tick
`ifdef HR12_MODE_EN
    ,
    output logic       pm
`endif
);

`ifdef HR12_MODE_EN
    localparam bcd_t c_hr_rst_tens = bcd_t'(HR12_MAX / 10);
    localparam bcd_t c_hr_rst_ones = bcd_t'(HR12_MAX % 10);
`else
    localparam bcd_t c_hr_rst_tens = 4'd0;
    localparam bcd_t c_hr_rst_ones = 4'd0;
`endif

    bcd_t      r_sec_1s, r_sec_10s, r_min_1s, r_min_10s, r_hr_1s, r_hr_10s;
    logic      r_pm;
    logic      w_set;
    logic      w_tick;
    bcd_pair_t w_sec_inc, w_min_inc, w_hr_inc;

    assign w_set = set_min | set_hr;

    tick_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .clr      (w_set),
        .sec_tick (w_tick)
    );

    assign w_sec_inc = inc_bcd60(r_sec_10s, r_sec_1s, SEC_MAX_TENS);
    assign w_min_inc = inc_bcd60(r_min_10s, r_min_1s, MIN_MAX_TENS);
`ifdef HR12_MODE_EN
    assign w_hr_inc  = inc_hr12(r_hr_10s, r_hr_1s);
`else
    assign w_hr_inc  = inc_hr24(r_hr_10s, r_hr_1s);
`endif

    // A set pulse overrides any pending tick so the cascade never double-steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_1s  <= 4'd0;
            r_sec_10s <= 4'd0;
            r_min_1s  <= 4'd0;
            r_min_10s <= 4'd0;
            r_hr_1s   <= c_hr_rst_ones;
            r_hr_10s  <= c_hr_rst_tens;
            r_pm      <= 1'b0;
        end else if (w_set) begin
            r_sec_1s  <= 4'd0;
            r_sec_10s <= 4'd0;
            if (set_min) begin
                r_min_1s  <= w_min_inc.ones;
                r_min_10s <= w_min_inc.tens;
            end
            if (set_hr) begin
                r_hr_1s  <= w_hr_inc.ones;
                r_hr_10s <= w_hr_inc.tens;
                r_pm     <= r_pm ^ w_hr_inc.carry;
            end
        end else if (w_tick) begin
            r_sec_1s  <= w_sec_inc.ones;
            r_sec_10s <= w_sec_inc.tens;
            if (w_sec_inc.carry) begin
                r_min_1s  <= w_min_inc.ones;
                r_min_10s <= w_min_inc.tens;
                if (w_min_inc.carry) begin
                    r_hr_1s  <= w_hr_inc.ones;
                    r_hr_10s <= w_hr_inc.tens;
                    r_pm     <= r_pm ^ w_hr_inc.carry;
                end
            end
        end
    end

    assign sec_1s   = r_sec_1s;
    assign sec_10s  = r_sec_10s;
    assign min_1s   = r_min_1s;
    assign min_10s  = r_min_10s;
    assign hr_1s    = r_hr_1s;
    assign hr_10s   = r_hr_10s;
    assign sec_tick = w_tick;
`ifdef HR12_MODE_EN
    assign pm       = r_pm;
`else
    logic w_unused;
    assign w_unused = r_pm;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_time_counter.sv
// ============================================================================
// Module      : tb_bcd_time_counter
// Description : Self-checking bench; time-of-day model in seconds since
//               midnight. Honours HR12_MODE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_time_counter;

    localparam int F = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       set_min = 1'b0;
    logic       set_hr = 1'b0;
    logic [3:0] sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;
    logic       sec_tick;
    logic       pm_obs;
`ifdef HR12_MODE_EN
    logic       pm;
    assign pm_obs = pm;
`else
    assign pm_obs = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    bcd_time_counter #(.CLK_FREQ_HZ(F)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .set_min(set_min), .set_hr(set_hr),
        .sec_1s(sec_1s), .sec_10s(sec_10s), .min_1s(min_1s), .min_10s(min_10s),
        .hr_1s(hr_1s), .hr_10s(hr_10s), .sec_tick(sec_tick)
`ifdef HR12_MODE_EN
        , .pm(pm)
`endif
    );

    always #5 clk = ~clk;

    // Model: time as seconds since midnight, prescaler as integer phase.
    int m_t = 0;
    int m_pc = 0;
    bit m_tick = 1'b0;

    function automatic int set_time(int t, bit sm, bit sh);
        int h, m;
        h = t / 3600;
        m = (t / 60) % 60;
        if (sm) m = (m + 1) % 60;
        if (sh) h = (h + 1) % 24;
        return h * 3600 + m * 60;
    endfunction

    function automatic logic [23:0] digits_of(int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
`ifdef HR12_MODE_EN
        h = (h % 12 == 0) ? 12 : h % 12;
`endif
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic bit pm_of(int t);
`ifdef HR12_MODE_EN
        return t >= 12 * 3600;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0;
            m_pc <= 0;
            m_tick <= 1'b0;
        end else if (set_min || set_hr) begin
            m_t <= set_time(m_t, set_min, set_hr);
            m_pc <= 0;
            m_tick <= 1'b0;
        end else begin
            if (m_tick) m_t <= (m_t + 1) % 86400;
            if (run) begin
                m_pc <= (m_pc == F - 1) ? 0 : m_pc + 1;
                m_tick <= (m_pc == F - 1);
            end else begin
                m_tick <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] dut_digits();
        return {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s};
    endfunction

    always @(negedge clk) begin
        check("model_digits", int'(dut_digits()), int'(digits_of(m_t)));
        check("model_tick", int'(sec_tick), int'(m_tick));
        check("model_pm", int'(pm_obs), int'(pm_of(m_t)));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit m, input bit h, input int n);
        repeat (n) begin
            set_min = m;
            set_hr = h;
            @(negedge clk);
            set_min = 1'b0;
            set_hr = 1'b0;
        end
    endtask

    task automatic wait_tick();
        int k;
        for (k = 0; k < 4 * F + 20; k++) begin
            @(negedge clk);
            if (sec_tick) break;
        end
        if (k == 4 * F + 20) check("wait_tick_timeout", 1, 0);
    endtask

    task automatic wait_sec(input int target);
        int k;
        for (k = 0; k < 70 * F; k++) begin
            if (int'(sec_10s) * 10 + int'(sec_1s) == target) break;
            @(negedge clk);
        end
        if (k == 70 * F) check("wait_sec_timeout", 1, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        run = 1'b1;
    endtask

`ifdef HR12_MODE_EN
    localparam logic [23:0] HR0 = 24'h120000;
`else
    localparam logic [23:0] HR0 = 24'h000000;
`endif

    initial begin
        int gap;
        // Reset state and first-tick latency
        cyc(1);
        check("reset_digits", int'(dut_digits()), int'(HR0));
        check("reset_tick", int'(sec_tick), 0);
        rst_n = 1'b1;
        run = 1'b1;
        cyc(3);
        check("no_tick_cycle3", int'(sec_tick), 0);
        cyc(1);
        check("first_tick_cycle4", int'(sec_tick), 1);
        cyc(1);
        check("sec_after_first", int'(dut_digits()), int'(HR0 | 24'h1));
        check("tick_one_cycle", int'(sec_tick), 0);

`ifndef HR12_MODE_EN
        // Rollover 23:59:59 -> 00:00:00
        pulse(0, 1, 23);
        pulse(1, 0, 59);
        wait_sec(58);
        wait_tick();
        cyc(1);
        check("at_235959", int'(dut_digits()), 24'h235959);
        wait_tick();
        cyc(1);
        check("rollover_000000", int'(dut_digits()), 24'h000000);

        // set_min at 12:59:37, set_hr at 23:xx
        do_reset();
        pulse(0, 1, 12);
        pulse(1, 0, 59);
        wait_sec(37);
        pulse(1, 0, 1);
        check("set_min_wrap", int'(dut_digits()), 24'h120000);
        pulse(0, 1, 11);
        pulse(1, 0, 5);
        wait_sec(3);
        pulse(0, 1, 1);
        check("set_hr_wrap", int'(dut_digits()), 24'h000500);

        // Set coincident with tick at 10:20:59
        do_reset();
        pulse(0, 1, 10);
        pulse(1, 0, 20);
        wait_sec(59);
        wait_tick();
        pulse(1, 0, 1);
        check("set_with_tick", int'(dut_digits()), 24'h102100);
`else
        // 11:59:59 -> 12:00:00 PM, then set_hr 12 -> 01 keeps pm
        do_reset();
        pulse(0, 1, 11);
        pulse(1, 0, 59);
        wait_sec(59);
        check("pm_before", int'(pm_obs), 0);
        wait_tick();
        cyc(1);
        check("hr12_noon", int'(dut_digits()), 24'h120000);
        check("pm_after_noon", int'(pm_obs), 1);
        pulse(0, 1, 1);
        check("hr12_set_one", int'(dut_digits()), 24'h010000);
        check("pm_kept", int'(pm_obs), 1);
`endif

        // run=0 for 10 cycles stretches the tick period by exactly 10
        wait_tick();
        cyc(2);
        run = 1'b0;
        cyc(10);
        run = 1'b1;
        gap = 2 + 10;
        while (!sec_tick && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        check("stretched_period", gap, F + 10);

        // Randomized run/set activity
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom_range(0, 7) != 0);
            set_min = ($urandom_range(0, 24) == 0);
            set_hr = ($urandom_range(0, 40) == 0);
            @(negedge clk);
        end
        set_min = 1'b0;
        set_hr = 1'b0;
        run = 1'b1;

        // Asynchronous reset mid-count
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_digits", int'(dut_digits()), int'(HR0));
        check("async_reset_tick", int'(sec_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3 * F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_time_counter.md
# bcd_time_counter

Timekeeping core of the digital clock: divides the board clock down to a 1 Hz tick and maintains seconds, minutes and hours as six packed BCD digits. It sits directly upstream of the seven-segment display driver, which consumes its digit outputs unchanged. It also accepts single-cycle set pulses from the (already debounced) button logic, so the user can adjust minutes and hours.

## Interface
- CLK_FREQ_HZ, 100_000_000, input clock frequency; prescaler terminal count is CLK_FREQ_HZ-1 (must be ≥2)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- run  input  1  1 = time advances; 0 = prescaler frozen, set pulses still honoured
- set_min  input  1  single-cycle pulse: minute +1
- set_hr  input  1  single-cycle pulse: hour +1
- sec_1s, sec_10s  output  4 each  seconds BCD units/tens
- min_1s, min_10s  output  4 each  minutes BCD units/tens
- hr_1s, hr_10s  output  4 each  hours BCD units/tens
- sec_tick  output  1  one-cycle pulse, registered, once per second
- pm  output  1  only with HR12_MODE_EN; 1 = PM

## Operation
- One clock, asynchronous active-low reset.
- Reset (async assert): prescaler=0, sec_tick=0, all digits 0 (00:00:00); under HR12_MODE_EN hours=12, pm=0.
- Prescaler counts 0..CLK_FREQ_HZ-1 while run=1; on the edge leaving terminal count it wraps to 0 and sec_tick is 1 for exactly one cycle.
- Digit update when sec_tick=1 (cascade, all in one edge):
  - sec_1s 9→0 carries to sec_10s; sec_10s 5→0 (at :59) carries to minutes.
  - Minutes use the same 59→00 rule and carry to hours.
  - Hours (24h): 23→00; hr_1s 9→0 with hr_10s+1 otherwise.
- set_min: minutes +1, 59→00 with no carry into hours; seconds cleared to 00; prescaler cleared to 0.
- set_hr: hours +1 with wrap (23→00), no effect on minutes; seconds and prescaler cleared.
- Simultaneous events:
  - Set pulse(s) in the same cycle as sec_tick: set wins, the tick's cascade is discarded.
  - set_min and set_hr together: both applied.
- Digits never take a non-BCD value; tens digits never exceed 5 (min/sec) or 2 (hr).
- run=0: prescaler holds its value; resuming continues from the held count (no tick lost or added).

## Timing
- First sec_tick: high during cycle CLK_FREQ_HZ after rst_n deassertion (run=1 throughout).
- Digits change on the edge after sec_tick is high; 1-cycle lag, all six digits update together.
- Set pulse sampled at edge N; digits show new value after edge N; next sec_tick a full CLK_FREQ_HZ cycles later.
- All outputs registered; no combinational input→output path.

## Configuration
- HR12_MODE_EN defined: 12-hour sequence 12,01,…,11,12; pm toggles on 11:59:59→12:00:00 and on set_hr 11→12; set_hr 12→01 leaves pm. pm port present.
- Undefined: 24-hour sequence 00..23, no pm port.

## Structure
- Package clock_pkg: 4-bit BCD digit type, constants SEC_MAX_TENS=5, MIN_MAX_TENS=5, HR24_MAX=23, HR12_MIN=1/HR12_MAX=12.
- Sub-module tick_gen: prescaler with run enable, synchronous clear (from set logic), sec_tick output; parameter CLK_FREQ_HZ.
- Top holds the BCD cascade and set logic.

## Test plan
- CLK_FREQ_HZ=4, reset then run=1 → sec_tick every 4 cycles, first at cycle 4; sec_1s=1 one cycle later.
- Preload to 23:59:58 via set pulses, two ticks → 23:59:59 then 00:00:00 in one edge.
- run=0 for 10 cycles mid-count → tick period stretched by exactly 10 cycles, no digit change meanwhile.
- set_min at 12:59:37 → 12:00:00, hours unchanged; set_hr at 23:xx → 00:xx:00.
- set_min coincident with sec_tick at 10:20:59 → 10:21:00 exactly (no double increment); rst_n pulsed mid-count → immediate 00:00:00, sec_tick=0.
- HR12_MODE_EN: 11:59:59 + tick → 12:00:00, pm 0→1; set_hr at 12 → 01, pm unchanged.
